// File: rtl/mult_arbiter.sv
// Round-robin arbiter sharing one signed multiplier among NREQ requesters.
// Response LAT cycles after accept, in accept order; the pipeline never stalls and responses cannot be back-pressured.
module mult_arbiter #(
  parameter int WIDTH = 16,
  parameter int NREQ  = 4,
  parameter int LAT   = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*WIDTH-1:0]   req_a,
  input  logic [NREQ*WIDTH-1:0]   req_b,
  output logic [NREQ-1:0]         req_ready,
  output logic [NREQ-1:0]         rsp_valid,
  output logic [2*WIDTH-1:0]      rsp_product,
  output logic                    busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0]            ptr;
  logic [PW-1:0]            gidx;
  logic [PW-1:0]            nxt_ptr;
  logic                     gnt_any;
  logic [NREQ-1:0]          gnt;
  logic [PW-1:0]            sel;
  int                       idx;

  logic signed [WIDTH-1:0]   a_arr [NREQ];
  logic signed [WIDTH-1:0]   b_arr [NREQ];
  logic signed [WIDTH-1:0]   a_sel;
  logic signed [WIDTH-1:0]   b_sel;
  logic signed [2*WIDTH-1:0] mul;

  logic [LAT-1:0]           vld;
  logic [NREQ-1:0]          tag  [LAT];
  logic [2*WIDTH-1:0]       prod [LAT];

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      a_arr[i] = req_a[i*WIDTH +: WIDTH];
      b_arr[i] = req_b[i*WIDTH +: WIDTH];
    end
  end

  // First valid requester at or after the pointer, wrapping past NREQ-1.
  always_comb begin
    gnt_any = 1'b0;
    gidx    = '0;
    idx     = 0;
    sel     = '0;
    gnt     = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      sel = PW'(idx);
      if (!gnt_any && en && !rst && req_valid[sel]) begin
        gnt_any = 1'b1;
        gidx    = sel;
      end
    end
    if (gnt_any) gnt[gidx] = 1'b1;
  end

  assign req_ready = gnt;
  assign nxt_ptr   = (gidx == PW'(NREQ - 1)) ? '0 : gidx + PW'(1);
  assign a_sel     = a_arr[gidx];
  assign b_sel     = b_arr[gidx];
  assign mul       = (2*WIDTH)'(a_sel) * (2*WIDTH)'(b_sel);

  // Data registers load only behind a valid bit, so the last stage holds the previous product.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
      vld <= '0;
      for (int i = 0; i < LAT; i++) begin
        tag[i]  <= '0;
        prod[i] <= '0;
      end
    end else begin
      if (gnt_any) begin
        ptr     <= nxt_ptr;
        prod[0] <= mul;
      end
      vld[0] <= gnt_any;
      tag[0] <= gnt;
      for (int i = 1; i < LAT; i++) begin
        vld[i] <= vld[i-1];
        tag[i] <= tag[i-1];
        if (vld[i-1]) prod[i] <= prod[i-1];
      end
    end
  end

  assign rsp_valid   = tag[LAT-1];
  assign rsp_product = prod[LAT-1];
  assign busy        = |vld;

endmodule

// File: tb/tb_mult_arbiter.sv
// Directed bench for mult_arbiter: grants checked inline, responses checked by a queue-driven monitor.
module tb_mult_arbiter;

  localparam int WIDTH = 16;
  localparam int NREQ  = 4;
  localparam int LAT   = 2;

  logic                  clk;
  logic                  rst;
  logic                  en;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ-1:0]       rsp_valid;
  logic [2*WIDTH-1:0]    rsp_product;
  logic                  busy;

  typedef struct packed {
    logic [3:0]  tag;
    logic [31:0] prod;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;
  logic [31:0] last_prod = '0;

  mult_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .LAT(LAT)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .req_valid   (req_valid),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_ready   (req_ready),
    .rsp_valid   (rsp_valid),
    .rsp_product (rsp_product),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] pk(input logic [15:0] o0, input logic [15:0] o1,
                                     input logic [15:0] o2, input logic [15:0] o3);
    return {o3, o2, o1, o0};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Checks the combinational grant and queues the response it should cause.
  task automatic expect_grant(input logic [3:0] exp_rdy, input logic [31:0] exp_p, input string nm);
    #1;
    chk(nm, 32'(req_ready), 32'(exp_rdy));
    if (exp_rdy != 4'b0) sb.push_back('{exp_rdy, exp_p, cyc + LAT});
  endtask

  task automatic drive(input logic e, input logic [3:0] v, input logic [63:0] a, input logic [63:0] b,
                       input logic [3:0] exp_rdy, input logic [31:0] exp_p, input string nm);
    @(negedge clk);
    en        = e;
    req_valid = v;
    req_a     = a;
    req_b     = b;
    expect_grant(exp_rdy, exp_p, nm);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 4'b0000, req_a, req_b, 4'b0000, 32'h0, "idle_rdy");
  endtask

  // Monitor: every response must match the queue head in tag, product and cycle.
  always @(negedge clk) begin
    if (rst) begin
      last_prod = '0;
    end else if (rsp_valid !== 4'b0) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL rsp_unexpected: rsp_valid=%b product=%h at cycle %0d", rsp_valid, rsp_product, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (rsp_valid !== e.tag || rsp_product !== e.prod || cyc != e.cyc) begin
          failures++;
          $display("FAIL rsp: rsp_valid=%b product=%h cycle=%0d expected %b %h cycle=%0d",
                   rsp_valid, rsp_product, cyc, e.tag, e.prod, e.cyc);
        end
      end
      last_prod = rsp_product;
    end else begin
      checks++;
      if (rsp_product !== last_prod) begin
        failures++;
        $display("FAIL rsp_hold: product=%h expected %h", rsp_product, last_prod);
      end
      if (sb.size() > 0 && sb[0].cyc <= cyc) begin
        exp_t e;
        e = sb.pop_front();
        checks++;
        failures++;
        $display("FAIL rsp_missing: rsp_valid=%b expected %b at cycle %0d", rsp_valid, e.tag, e.cyc);
      end
    end
  end

  logic [63:0] a_rr, b_rr;

  initial begin
    a_rr      = pk(16'd1, 16'd2, 16'd3, 16'd4);
    b_rr      = pk(16'd10, 16'd20, 16'd30, 16'd40);
    rst       = 1'b1;
    en        = 1'b1;
    req_valid = 4'b1111;
    req_a     = a_rr;
    req_b     = b_rr;

    // Reset state with all requesters asking
    repeat (3) @(negedge clk);
    #1;
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_product", rsp_product, 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);

    // Release: first edge accepts; all four held valid rotate 0,1,2,3,0,1
    rst = 1'b0;
    expect_grant(4'b0001, 32'd10, "rr_0");
    drive(1'b1, 4'b1111, a_rr, b_rr, 4'b0010, 32'd40,  "rr_1");
    drive(1'b1, 4'b1111, a_rr, b_rr, 4'b0100, 32'd90,  "rr_2");
    drive(1'b1, 4'b1111, a_rr, b_rr, 4'b1000, 32'd160, "rr_3");
    drive(1'b1, 4'b1111, a_rr, b_rr, 4'b0001, 32'd10,  "rr_4");
    drive(1'b1, 4'b1111, a_rr, b_rr, 4'b0010, 32'd40,  "rr_5");
    idle(3);
    chk("drain_busy", 32'(busy), 32'h0);

    // Single requester 2: 3 * -5
    drive(1'b1, 4'b0100, pk(16'd0, 16'd0, 16'd3, 16'd0), pk(16'd0, 16'd0, -16'sd5, 16'd0),
          4'b0100, 32'hFFFFFFF1, "single_2");

    // Pointer at 3 with requesters 1 and 3: 3 then 1, wrap to 0 then 2
    drive(1'b1, 4'b1010, a_rr, b_rr, 4'b1000, 32'd160, "wrap_3");
    drive(1'b1, 4'b0010, a_rr, b_rr, 4'b0010, 32'd40,  "wrap_1");
    drive(1'b1, 4'b1011, a_rr, b_rr, 4'b1000, 32'd160, "ptr_at_2");
    idle(3);

    // Corner operands from requester 0, back to back
    drive(1'b1, 4'b0001, pk(16'h8000, 16'd0, 16'd0, 16'd0), pk(16'h8000, 16'd0, 16'd0, 16'd0),
          4'b0001, 32'h40000000, "corner_min_min");
    drive(1'b1, 4'b0001, pk(16'h8000, 16'd0, 16'd0, 16'd0), pk(16'h7FFF, 16'd0, 16'd0, 16'd0),
          4'b0001, 32'hC0008000, "corner_min_max");
    drive(1'b1, 4'b0001, pk(16'h0000, 16'd0, 16'd0, 16'd0), pk(16'hFFFF, 16'd0, 16'd0, 16'd0),
          4'b0001, 32'h00000000, "corner_zero");
    idle(3);

    // en low with one op in flight: no grants, response still delivered
    drive(1'b1, 4'b0010, a_rr, b_rr, 4'b0010, 32'd40, "en_pre");
    drive(1'b0, 4'b1111, a_rr, b_rr, 4'b0000, 32'h0, "en_off_0");
    chk("en_busy_0", 32'(busy), 32'h1);
    drive(1'b0, 4'b1111, a_rr, b_rr, 4'b0000, 32'h0, "en_off_1");
    chk("en_busy_1", 32'(busy), 32'h1);
    drive(1'b0, 4'b1111, a_rr, b_rr, 4'b0000, 32'h0, "en_off_2");
    chk("en_busy_2", 32'(busy), 32'h0);
    drive(1'b1, 4'b1111, a_rr, b_rr, 4'b0100, 32'd90, "en_ptr_held");
    drive(1'b1, 4'b0111, a_rr, b_rr, 4'b0001, 32'd10, "pre_rst");

    // Reset with two operations in flight; pointer is 1 beforehand
    @(posedge clk);
    #1;
    rst = 1'b1;
    sb.delete();
    #1;
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("midrst_busy", 32'(busy), 32'h0);
    req_valid = 4'b1111;
    @(negedge clk);
    #1;
    chk("midrst_ready", 32'(req_ready), 32'h0);
    rst = 1'b0;
    expect_grant(4'b0001, 32'd10, "post_rst_ptr0");
    idle(4);

    chk("sb_empty", 32'(sb.size()), 32'h0);
    chk("end_busy", 32'(busy), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mult_arbiter.md
MULT_ARBITER -- requirements
Module: mult_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, meaning the operand width in bits (signed two's complement).
REQ-002 The block SHALL have parameter NREQ, default 4, meaning the number of requesters sharing one multiplier (2..8).
REQ-003 The block SHALL have parameter LAT, default 2, meaning the cycles from accept to response (1..4).
REQ-004 Port clk  in  1  clock; all state SHALL update on the rising edge.
REQ-005 Port rst  in  1  reset, asynchronous, active-high.
REQ-006 Port en  in  1  grant enable; when low, no new requests are accepted.
REQ-007 Port req_valid  in  NREQ  per-requester operand-valid.
REQ-008 Port req_a  in  NREQ*WIDTH  packed operand A; requester i occupies bits [i*WIDTH +: WIDTH].
REQ-009 Port req_b  in  NREQ*WIDTH  packed operand B; same packing as req_a.
REQ-010 Port req_ready  out  NREQ  one-hot grant/accept strobe.
REQ-011 Port rsp_valid  out  NREQ  one-hot, single-cycle response strobe for the owning requester.
REQ-012 Port rsp_product  out  2*WIDTH  signed product, broadcast to all requesters.
REQ-013 Port busy  out  1  high while any accepted operation is in flight.

Function
REQ-014 req_ready SHALL be combinational from req_valid, en and the round-robin pointer; at most one bit SHALL be set per cycle.
REQ-015 Grant search SHALL start at pointer index p and proceed p, p+1, ..., wrapping NREQ-1 to 0; the first valid requester found SHALL be granted.
REQ-016 With en=0 or req_valid=0, req_ready SHALL be all zeros and the pointer SHALL hold.
REQ-017 A transfer SHALL occur when req_valid[i] & req_ready[i] are both high; operands SHALL be sampled at that edge.
REQ-018 A requester SHALL hold valid and operands stable until accepted; the block SHALL NOT depend on early deassertion.
REQ-019 After a transfer from requester i, the pointer SHALL become (i+1) mod NREQ at the next edge.
REQ-020 Throughput SHALL be one accept per cycle; the pipeline SHALL never stall and responses SHALL NOT be back-pressured.
REQ-021 An accept at edge t SHALL produce rsp_valid[i]=1 for exactly the cycle following edge t+LAT-1, i.e. LAT cycles after the accept cycle.
REQ-022 Responses SHALL emerge in accept order.
REQ-023 rsp_product SHALL equal signed(a)*signed(b) at full 2*WIDTH width, with no saturation or rounding.
REQ-024 rsp_product SHALL be valid only while rsp_valid is nonzero; otherwise it SHALL hold its last value.
REQ-025 Each pipeline stage SHALL carry a valid bit and a one-hot requester tag alongside the data.
REQ-026 busy SHALL be the OR of all pipeline-stage valid bits.
REQ-027 Deasserting en SHALL block new accepts only; in-flight operations SHALL still complete and respond.
REQ-028 A requester may re-request in the cycle after its accept; it SHALL be re-granted only when round-robin order reaches it.

Reset
REQ-029 While rst=1, the pointer SHALL be 0, all pipeline valid bits and tags SHALL be 0, rsp_valid SHALL be 0, rsp_product SHALL be 0, busy SHALL be 0, and req_ready SHALL be 0.
REQ-030 Assertion of rst mid-operation SHALL discard all in-flight operations; no rsp_valid SHALL occur for them after release.
REQ-031 After rst deasserts, the first accept SHALL be possible on the first rising edge.

Verification (WIDTH=16, NREQ=4, LAT=2)
REQ-032 Only req_valid[2] set, a=3, b=-5, accepted at cycle t -> rsp_valid=4'b0100 at t+2 only, rsp_product=0xFFFFFFF1.
REQ-033 All four requesters held valid from reset -> accept order 0,1,2,3,0,1 with one accept per cycle, and rsp_valid following the same order delayed by 2.
REQ-034 Corner operands: a=b=-32768 -> 0x40000000; a=-32768, b=32767 -> 0xC0008000; a=0, b=-1 -> 0x00000000.
REQ-035 Pointer=3 after an accept from requester 2, with requesters 1 and 3 valid -> 3 granted first, then 1; pointer wraps to 0, then 2.
REQ-036 rst pulsed with two operations in flight -> no rsp_valid afterwards, busy=0, next grant search starts at 0.
REQ-037 en=0 with all requests valid and one operation in flight -> req_ready=0, in-flight response still delivered, busy falls after 2 cycles.
